// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 16/8 restoring divider.
// Latency: n/a (declarations only). Backpressure: n/a.
package div_pkg;

  localparam int W = 8;
  localparam int STEPS = W;
  localparam logic [7:0] Q_SAT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef struct packed {
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         overflow;
    logic         div_by_zero;
  } res_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
// Latency: combinational. Backpressure: none, pure datapath.
module div_step #(
  parameter int W = 8
) (
  input  logic [W:0]   r_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   r_out,
  output logic         qbit
);

  logic [W:0] t;
  // R stays below the divisor, so its top bit never carries information.
  logic       r_msb_unused;

  assign r_msb_unused = r_in[W];
  assign t            = {r_in[W-1:0], bit_in};

  always_comb begin
    r_out = t;
    qbit  = 1'b0;
    if (t >= {1'b0, divisor}) begin
      r_out = t - {1'b0, divisor};
      qbit  = 1'b1;
    end
  end

endmodule

// File: rtl/seq_div_16by8.sv
// Iterative 16/8 unsigned restoring divider, one quotient bit per clock.
// Latency: 8 cycles normal, 1 cycle div-by-zero/overflow. Result held until out_ready.
module seq_div_16by8
  import div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           overflow,
  output logic           div_by_zero
);

  localparam int CW = $clog2(STEPS);

  state_t        state, state_nxt;
  logic [W:0]    r_q;
  logic [W-1:0]  q_q;
  logic [W-1:0]  dsr_q;
  logic [CW-1:0] cnt;
  logic          flagged;
  logic          ov_q;
  logic          dz_q;
  logic [W:0]    r_nxt;
  logic          qbit;
  logic          accept;
  res_t          res;

  assign accept = in_valid && (state == IDLE);

  div_step #(.W(W)) u_step (
    .r_in    (r_q),
    .bit_in  (q_q[W-1]),
    .divisor (dsr_q),
    .r_out   (r_nxt),
    .qbit    (qbit)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Flagged operations also pass through one CALC cycle (with the datapath frozen)
  // so their result appears one cycle after accept.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (flagged || cnt == CW'(STEPS - 1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_q     <= '0;
      q_q     <= '0;
      dsr_q   <= '0;
      cnt     <= '0;
      flagged <= 1'b0;
      ov_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else if (accept) begin
      dsr_q <= divisor;
      cnt   <= '0;
      if (divisor == '0) begin
        flagged <= 1'b1;
        dz_q    <= 1'b1;
        ov_q    <= 1'b0;
        q_q     <= Q_SAT;
        r_q     <= '0;
      end else if (dividend[2*W-1:W] >= divisor) begin
        flagged <= 1'b1;
        dz_q    <= 1'b0;
        ov_q    <= 1'b1;
        q_q     <= Q_SAT;
        r_q     <= '0;
      end else begin
        flagged <= 1'b0;
        dz_q    <= 1'b0;
        ov_q    <= 1'b0;
        q_q     <= dividend[W-1:0];
        r_q     <= {1'b0, dividend[2*W-1:W]};
      end
    end else if (state == CALC && !flagged) begin
      r_q <= r_nxt;
      q_q <= {q_q[W-2:0], qbit};
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    res = '0;
    if (state == DONE) begin
      res.quotient    = q_q;
      res.remainder   = r_q[W-1:0];
      res.overflow    = ov_q;
      res.div_by_zero = dz_q;
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign quotient    = res.quotient;
  assign remainder   = res.remainder;
  assign overflow    = res.overflow;
  assign div_by_zero = res.div_by_zero;

endmodule

// File: tb/tb_seq_div_16by8.sv
// Directed and random checks of seq_div_16by8 against hand-computed and integer-division results.
module tb_seq_div_16by8;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        overflow;
  logic        div_by_zero;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  seq_div_16by8 dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present operands on a falling edge and let the next rising edge accept them;
  // the inputs are then scrambled to show they were captured.
  task automatic start_op(input logic [15:0] dd, input logic [7:0] dv);
    int n;
    n = 0;
    @(negedge CLK);
    while (!in_ready && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("ready_before_accept", in_ready, 1);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    dividend = 16'hA5A5;
    divisor  = 8'h3C;
  endtask

  // Number of rising edges after the accept edge until out_valid is seen; -1 on timeout.
  task automatic wait_result(output int lat);
    lat = -1;
    for (int k = 0; k <= 20; k++) begin
      if (out_valid) begin
        lat = k;
        break;
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_op(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                       input int exp_lat, input logic [7:0] exp_q, input logic [7:0] exp_r,
                       input logic exp_ov, input logic exp_dz, input int hold);
    int lat;
    start_op(dd, dv);
    wait_result(lat);
    chk({tag, "_latency"}, lat, exp_lat);
    repeat (hold) begin
      @(posedge CLK);
      #1;
    end
    chk({tag, "_quotient"}, quotient, exp_q);
    chk({tag, "_remainder"}, remainder, exp_r);
    chk({tag, "_overflow"}, overflow, exp_ov);
    chk({tag, "_div_by_zero"}, div_by_zero, exp_dz);
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
    chk({tag, "_back_to_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int lat;
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [7:0]  eq, er;
    logic        eov, edz;
    int          elat;

    repeat (2) @(negedge CLK);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_flags", {overflow, div_by_zero}, 0);
    RST_N = 1'b1;

    do_op("basic", 16'h1234, 8'h56, 8, 8'h36, 8'h10, 1'b0, 1'b0, 0);
    do_op("max_quot", 16'hFE01, 8'hFF, 8, 8'hFF, 8'h00, 1'b0, 1'b0, 0);
    do_op("div_zero", 16'h1234, 8'h00, 1, 8'hFF, 8'h00, 1'b0, 1'b1, 0);
    do_op("overflow", 16'h5000, 8'h50, 1, 8'hFF, 8'h00, 1'b1, 1'b0, 0);
    do_op("remainder_max", 16'h00FF, 8'h10, 8, 8'h0F, 8'h0F, 1'b0, 1'b0, 0);

    // Backpressure with competing operands on the input side.
    start_op(16'h1234, 8'h56);
    wait_result(lat);
    chk("bp_latency", lat, 8);
    in_valid = 1'b1;
    dividend = 16'h0001;
    divisor  = 8'h01;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK);
      #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_quotient", quotient, 8'h36);
      chk("bp_remainder", remainder, 8'h10);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
    chk("bp_release", {out_valid, in_ready}, 2'b01);
    @(posedge CLK);
    #1;
    chk("bp_no_stale_op", {out_valid, in_ready}, 2'b01);

    // Asynchronous reset in the middle of a calculation.
    start_op(16'h1234, 8'h56);
    repeat (4) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_out_valid", out_valid, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    chk("rst_after_out_valid", out_valid, 0);
    chk("rst_after_in_ready", in_ready, 1);
    do_op("post_rst", 16'h0100, 8'h02, 8, 8'h80, 8'h00, 1'b0, 1'b0, 0);

    for (int i = 0; i < 3000; i++) begin
      dv = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      if (dv != 0 && $urandom_range(0, 1) == 1)
        dd = 16'($urandom_range(0, int'(dv) * 256 - 1));
      else
        dd = 16'($urandom_range(0, 16'hFFFF));
      if (dv == 0) begin
        edz = 1'b1; eov = 1'b0; eq = 8'hFF; er = 8'h00; elat = 1;
      end else if (dd[15:8] >= dv) begin
        edz = 1'b0; eov = 1'b1; eq = 8'hFF; er = 8'h00; elat = 1;
      end else begin
        edz = 1'b0; eov = 1'b0;
        eq = 8'(int'(dd) / int'(dv));
        er = 8'(int'(dd) % int'(dv));
        elat = 8;
      end
      do_op("rand", dd, dv, elat, eq, er, eov, edz, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
